dual_prio_serializer: RTL and testbench
=======================================

DUAL_PRIO_SERIALIZER -- requirements
Module: dual_prio_serializer

Interface
REQ-001 Parameters SHALL be none; widths are fixed by package constants (request 12 bits, code 4 bits).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  upstream offers a request vector.
REQ-005 req_ready  output  1  block can accept a request vector.
REQ-006 req  input  12  request vector; bit 11 has highest priority.
REQ-007 code_valid  output  1  first/second hold a valid beat.
REQ-008 code_ready  input  1  downstream (4-to-12 decoders) consumes the beat.
REQ-009 first  output  4  code of highest pending bit.
REQ-010 second  output  4  code of next-highest pending bit.
REQ-011 last  output  1  current beat empties the pending set.
REQ-012 busy  output  1  block is in BUSY.

Function
REQ-013 Code encoding SHALL be: 0 means none; k in 1..12 means request bit k-1; codes 13..15 are never produced.
REQ-014 The FSM SHALL have two states: IDLE and BUSY.
REQ-015 IDLE: req_ready=1, code_valid=0; req_valid=1 with req!=0 loads pending<=req and moves to BUSY; req_valid=1 with req==0 is accepted and dropped, staying in IDLE.
REQ-016 BUSY: req_ready=0, code_valid=1, busy=1.
REQ-017 Latency: acceptance in cycle N SHALL give code_valid=1 in cycle N+1.
REQ-018 first SHALL be the code of the highest set pending bit; second SHALL be the code of the highest set pending bit below it, or 0 if none.
REQ-019 last SHALL be 1 exactly when pending has one or two set bits.
REQ-020 On code_valid&&code_ready the bits named by first and second SHALL be cleared; if last=1, the FSM SHALL return to IDLE in the next cycle.
REQ-021 With code_valid=1 and code_ready=0, first, second, last and pending SHALL hold unchanged.
REQ-022 The IDLE cycle after the final beat is mandatory; there is no back-to-back acceptance.
REQ-023 All outputs SHALL be driven from registered state only; there is no combinational path from code_ready or req_valid to any output.

Reset
REQ-024 reset=1 SHALL force IDLE, pending=0, req_ready=1, code_valid=0, first=0, second=0, last=0 and busy=0 on the next edge.
REQ-025 reset during BUSY SHALL discard all pending bits; no further beats are issued for them.
REQ-026 reset SHALL take priority over simultaneous req_valid or code_ready.

Configuration
REQ-027 Macro DPE_CNT_EN defined: the block SHALL add the output cnt (4 bits), the popcount of the last accepted non-zero req, registered at acceptance, held until the next acceptance, and reset to 0.
REQ-028 Macro DPE_CNT_EN undefined: the cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package dpe_pkg SHALL hold REQ_W=12, CODE_W=4, CODE_NONE=0 and the FSM state typedef.
REQ-030 Sub-module prio_enc_12 SHALL be combinational: 12-bit vector in, 4-bit code out per REQ-013.
REQ-031 prio_enc_12 SHALL be instantiated twice: the second instance sees pending with the first winner masked.

Verification
REQ-032 req=0xC01 with code_ready=1 -> beat1 first=12, second=11, last=0; beat2 first=1, second=0, last=1; then IDLE.
REQ-033 req=0x000 with req_valid=1 -> accepted; code_valid stays 0; busy stays 0.
REQ-034 req=0xFFF with code_ready toggling 1/0 -> six beats (12,11)...(2,1); outputs held during stalls; last only on (2,1).
REQ-035 reset asserted in the cycle after accepting 0x0F0 -> next cycle IDLE, code_valid=0, first=second=0, and no beat ever for bits 4..7.
REQ-036 req_valid held high during BUSY with req=0x001 -> that vector is not accepted until the IDLE cycle following the last beat.
REQ-037 With DPE_CNT_EN defined, req=0x5A5 -> cnt=6 from the cycle after acceptance until the next acceptance.

Source files
------------

// File: rtl/dpe_pkg.sv
// rtl/dpe_pkg.sv - shared widths, FSM state type and bit/code helpers for dual_prio_serializer
package dpe_pkg;

    localparam int REQ_W = 12;
    localparam int CODE_W = 4;
    localparam logic [CODE_W-1:0] CODE_NONE = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Turn a code back into the single request bit it names; CODE_NONE names no bit.
    function automatic logic [REQ_W-1:0] code_mask(input logic [CODE_W-1:0] code);
        code_mask = '0;
        if (code != CODE_NONE) begin
            code_mask = REQ_W'(1) << (code - CODE_W'(1));
        end
    endfunction

    // Number of set bits in a request vector; twelve always fits in a code-wide field.
    function automatic logic [CODE_W-1:0] popcount(input logic [REQ_W-1:0] vec);
        popcount = '0;
        for (int i = 0; i < REQ_W; i++) begin
            popcount = popcount + CODE_W'(vec[i]);
        end
    endfunction

endpackage

// File: rtl/prio_enc_12.sv
// rtl/prio_enc_12.sv - combinational 12-bit priority encoder, bit 11 wins, code 0 means none
module prio_enc_12
    import dpe_pkg::*;
(
    input  logic [REQ_W-1:0]  vec,
    output logic [CODE_W-1:0] code
);

    // Scan upward so the highest set bit is the last one to overwrite the result.
    always_comb begin
        code = CODE_NONE;
        for (int i = 0; i < REQ_W; i++) begin
            if (vec[i]) begin
                code = CODE_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/dual_prio_serializer.sv
// rtl/dual_prio_serializer.sv - drains a request vector two priority codes per beat; optional DPE_CNT_EN adds cnt
module dual_prio_serializer
    import dpe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REQ_W-1:0]  req,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [CODE_W-1:0] first,
    output logic [CODE_W-1:0] second,
    output logic              last,
`ifdef DPE_CNT_EN
    output logic [CODE_W-1:0] cnt,
`endif
    output logic              busy
);

    state_t            state_q;
    state_t            state_d;
    logic [REQ_W-1:0]  pending_q;
    logic [REQ_W-1:0]  pending_d;
    logic [REQ_W-1:0]  masked_first;
    logic [REQ_W-1:0]  remaining;
    logic [CODE_W-1:0] first_code;
    logic [CODE_W-1:0] second_code;
    logic              load;

    prio_enc_12 u_enc_first (
        .vec  (pending_q),
        .code (first_code)
    );

    assign masked_first = pending_q & ~code_mask(first_code);

    prio_enc_12 u_enc_second (
        .vec  (masked_first),
        .code (second_code)
    );

    // What is left once this beat's two winners are gone; empty means this beat is the last.
    assign remaining = masked_first & ~code_mask(second_code);

    // Only non-zero vectors start a burst; zero vectors are accepted and dropped in IDLE.
    assign load = (state_q == ST_IDLE) && req_valid && (req != '0);

    // Next-state and pending update: load in IDLE, retire two bits per consumed beat in BUSY.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    pending_d = req;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (code_ready) begin
                    pending_d = remaining;
                    if (remaining == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State and pending register; reset discards any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Every output is decoded from the registered state and pending bits only.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        code_valid = (state_q == ST_BUSY);
        busy       = (state_q == ST_BUSY);
        first      = first_code;
        second     = second_code;
        last       = (pending_q != '0) && (remaining == '0);
    end

`ifdef DPE_CNT_EN
    // Popcount of the most recently loaded vector, held until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= popcount(req);
        end
    end
`endif

endmodule

// File: tb/tb_dual_prio_serializer.sv
// tb/tb_dual_prio_serializer.sv - randomized and directed self-checking bench for dual_prio_serializer
module tb_dual_prio_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req;
    logic        code_valid;
    logic        code_ready;
    logic [3:0]  first;
    logic [3:0]  second;
    logic        last;
    logic        busy;
`ifdef DPE_CNT_EN
    logic [3:0]  cnt;
`endif

    always #5 clk = ~clk;

    dual_prio_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req        (req),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .first      (first),
        .second     (second),
        .last       (last),
`ifdef DPE_CNT_EN
        .cnt        (cnt),
`endif
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: the pending set as a queue of codes in issue order.
    int q[$];
    bit m_busy = 1'b0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            q.delete();
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            if (req_valid && req != 12'h000) begin
                q.delete();
                for (int b = 11; b >= 0; b--) begin
                    if (req[b]) q.push_back(b + 1);
                end
                m_busy = 1'b1;
                m_cnt  = q.size();
            end
        end else if (code_ready) begin
            void'(q.pop_front());
            if (q.size() > 0) void'(q.pop_front());
            if (q.size() == 0) m_busy = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("req_ready", 32'(req_ready), 32'(!m_busy));
        chk("code_valid", 32'(code_valid), 32'(m_busy));
        chk("busy", 32'(busy), 32'(m_busy));
        if (m_busy) begin
            chk("first", 32'(first), 32'(q[0]));
            chk("second", 32'(second), (q.size() > 1) ? 32'(q[1]) : 32'd0);
            chk("last", 32'(last), 32'(q.size() <= 2));
        end
`ifdef DPE_CNT_EN
        chk("cnt", 32'(cnt), 32'(m_cnt));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    int beats;
    int guard;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req        = 12'h000;
        code_ready = 1'b0;
        @(negedge clk);
        step();
        chk("rst_first", 32'(first), 32'd0);
        chk("rst_second", 32'(second), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        reset = 1'b0;

        // 0xC01 with downstream always ready
        req_valid = 1'b1; req = 12'hC01; code_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("c01_b1_first", 32'(first), 32'd12);
        chk("c01_b1_second", 32'(second), 32'd11);
        chk("c01_b1_last", 32'(last), 32'd0);
        step();
        chk("c01_b2_first", 32'(first), 32'd1);
        chk("c01_b2_second", 32'(second), 32'd0);
        chk("c01_b2_last", 32'(last), 32'd1);
        step();
        chk("c01_idle", 32'(code_valid), 32'd0);

        // zero vector is accepted and dropped
        req_valid = 1'b1; req = 12'h000;
        step();
        req_valid = 1'b0;
        chk("zero_valid", 32'(code_valid), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_ready", 32'(req_ready), 32'd1);

        // 0xFFF with code_ready toggling
        req_valid = 1'b1; req = 12'hFFF; code_ready = 1'b0;
        step();
        req_valid = 1'b0;
        beats = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            code_ready = (guard % 2 == 0);
            if (code_ready) begin
                beats++;
                chk("fff_first", 32'(first), 32'(14 - 2 * beats));
                chk("fff_second", 32'(second), 32'(13 - 2 * beats));
                chk("fff_last", 32'(last), 32'(beats == 6));
            end
            step();
            guard++;
        end
        chk("fff_beats", 32'(beats), 32'd6);

        // reset right after accepting 0x0F0
        req_valid = 1'b1; req = 12'h0F0; code_ready = 1'b0;
        step();
        req_valid = 1'b0; reset = 1'b1; code_ready = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_busy_valid", 32'(code_valid), 32'd0);
        chk("rst_busy_first", 32'(first), 32'd0);
        chk("rst_busy_second", 32'(second), 32'd0);
        for (int i = 0; i < 4; i++) step();

        // next request held high while busy
        req_valid = 1'b1; req = 12'h00F; code_ready = 1'b1;
        step();
        req = 12'h001;
        step();
        step();
        chk("hold_idle_ready", 32'(req_ready), 32'd1);
        chk("hold_idle_busy", 32'(busy), 32'd0);
        step();
        req_valid = 1'b0;
        chk("hold_acc_busy", 32'(busy), 32'd1);
        chk("hold_acc_first", 32'(first), 32'd1);
        chk("hold_acc_last", 32'(last), 32'd1);
        step();

`ifdef DPE_CNT_EN
        req_valid = 1'b1; req = 12'h5A5; code_ready = 1'b0;
        step();
        req_valid = 1'b0;
        chk("cnt_5a5", 32'(cnt), 32'd6);
        for (int i = 0; i < 3; i++) step();
        chk("cnt_5a5_hold", 32'(cnt), 32'd6);
        code_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            req_valid  = ($urandom_range(0, 2) != 0);
            req        = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
            code_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
